pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter register and next-PC selector for the simple microprocessor.
- Drives the current PC to the instruction memory and to the PC incrementer, then consumes the incrementer's pc+1 result as the sequential next PC.
- Applies jump and branch redirects from execute, fetch stall and halt, and presents a valid/ready fetch handshake.

Parameters:
- width, 32, PC width in bits.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  out  width  current PC; feeds the incrementer din and the instruction memory address.
- pc_plus_one  in  width  incrementer dout (pc+1), combinational from pc.
- fetch_valid  out  1  pc is a valid fetch request.
- fetch_ready  in  1  instruction memory accepts the request this cycle.
- stall  in  1  pipeline stall; blocks sequential advance.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  width  branch destination.
- jump  in  1  unconditional jump.
- jump_target  in  width  jump destination.
- halt  in  1  halt request.
- halted  out  1  sequencer is in HALT.
- call  in  1  push return address; only with PC_RAS_EN.
- ret  in  1  pop return address; only with PC_RAS_EN.

Behaviour:
- Reset is asynchronous and active-high: one clock; reset is asynchronous and active-high. While rst is high: pc=RESET_PC, fetch_valid=0, halted=0, state=BOOT, RAS pointer=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - fetch_valid=0 for exactly one cycle after rst deasserts.
  - Next state RUN; pc is unchanged.
  - A halt in BOOT goes to HALT.
- RUN: fetch_valid=1. Next-PC priority, highest first:
  1. halt: state becomes HALT, pc frozen, fetch_valid=0 from the next cycle.
  2. jump: pc <= jump_target.
  3. branch_taken: pc <= branch_target.
  4. stall=0 and fetch_valid and fetch_ready: pc <= pc_plus_one.
  5. Otherwise pc holds.
- Redirects (jump and branch) take effect regardless of stall or fetch_ready. The in-flight request is abandoned, and the new pc is presented next cycle.
- Sequential advance:
  - Occurs only on a completed handshake with stall low.
  - fetch_ready without stall advances exactly once per cycle.
  - Holding fetch_ready low keeps pc and fetch_valid stable; valid is never withdrawn except by halt or rst.
- Latency: every update is registered, one cycle from input to pc.
- HALT: halted=1, fetch_valid=0, pc frozen; all inputs ignored. Exit is by rst only.
- Arithmetic: pc_plus_one is accepted as-is. Wrap from all-ones to 0 is legal and not flagged.
- halted is registered and goes high in the cycle the state becomes HALT.
- rst mid-operation: pc returns to RESET_PC immediately (asynchronous) and state returns to BOOT. Any pending request is dropped.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack, plus call and ret ports.
  - call with jump pushes pc_plus_one and redirects to jump_target.
  - ret pops the stack into pc, with the same priority as jump.
  - ret takes priority over jump when both are asserted.
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty leaves pc holding and the pointer unchanged.
  - call without jump is ignored.
- Undefined: no stack and no call/ret ports; the behaviour is exactly as described above.

Test Plan:
- Release rst with RESET_PC=0, fetch_ready=1 -> fetch_valid low for 1 cycle, then pc=0,1,2,3 on successive cycles.
- pc=5, fetch_ready=0 for 3 cycles -> pc stays 5 with fetch_valid=1; fetch_ready=1 -> pc=6.
- pc=10, stall=1 with branch_taken=1, branch_target=0x40 -> pc=0x40 next cycle; stall held -> pc holds 0x40.
- jump=1 (target 0x100) together with branch_taken=1 (target 0x200) -> pc=0x100.
- halt at pc=7 -> halted=1 and fetch_valid=0 next cycle, pc stays 7 despite jump. Then rst -> pc=0 and halted=0 asynchronously.
- PC_RAS_EN: call+jump at pc=3 (target 0x20), later ret -> pc=4. Five calls then five rets with RAS_DEPTH=4 -> the last ret leaves pc holding.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter register with next-PC selection (halt > ret > jump > branch > sequential).
// Optional return-address stack with call/ret ports, enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int unsigned      width     = 32,
    parameter logic [width-1:0] RESET_PC  = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [width-1:0] pc,
    input  logic [width-1:0] pc_plus_one,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [width-1:0] branch_target,
    input  logic             jump,
    input  logic [width-1:0] jump_target,
    input  logic             halt,
    output logic             halted
`ifdef PC_RAS_EN
    ,
    input  logic             call,
    input  logic             ret
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [width-1:0] pc_r;
    logic [width-1:0] pc_next_s;
    logic             fetch_valid_r;
    logic             halted_r;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [width-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_r;
    logic [CNT_W-1:0] ras_count_r;
    logic [PTR_W-1:0] ras_prev_s;
    logic [width-1:0] ras_top_s;
    logic             ras_push_s;
    logic             ras_pop_s;

    // Top-of-stack lookup; ras_ptr_r names the next free slot.
    always_comb begin
        if (ras_ptr_r == '0) begin
            ras_prev_s = PTR_W'(RAS_DEPTH - 1);
        end else begin
            ras_prev_s = ras_ptr_r - 1'b1;
        end
        ras_top_s = ras_mem_r[ras_prev_s];
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
`endif

    // Next-state and next-PC selection.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
`ifdef PC_RAS_EN
        ras_push_s   = 1'b0;
        ras_pop_s    = 1'b0;
`endif
        case (state_r)
            ST_BOOT: begin
                if (halt) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next_s = ST_HALT;
`ifdef PC_RAS_EN
                end else if (ret) begin
                    // An empty stack leaves pc where it is.
                    if (ras_count_r != '0) begin
                        pc_next_s = ras_top_s;
                        ras_pop_s = 1'b1;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end else if (jump) begin
                    pc_next_s  = jump_target;
                    ras_push_s = call;
`else
                end else if (jump) begin
                    pc_next_s = jump_target;
`endif
                end else if (branch_taken) begin
                    pc_next_s = branch_target;
                end else if (!stall && fetch_valid_r && fetch_ready) begin
                    pc_next_s = pc_plus_one;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // State, PC and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            fetch_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            fetch_valid_r <= (state_next_s == ST_RUN);
            halted_r      <= (state_next_s == ST_HALT);
        end
    end

`ifdef PC_RAS_EN
    // Circular return-address stack: a push when full overwrites the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_r   <= '0;
            ras_count_r <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_r[i] <= '0;
            end
        end else if (ras_push_s) begin
            ras_mem_r[ras_ptr_r] <= pc_plus_one;
            if (ras_ptr_r == PTR_W'(RAS_DEPTH - 1)) begin
                ras_ptr_r <= '0;
            end else begin
                ras_ptr_r <= ras_ptr_r + 1'b1;
            end
            if (ras_count_r != CNT_W'(RAS_DEPTH)) begin
                ras_count_r <= ras_count_r + 1'b1;
            end else begin
                ras_count_r <= ras_count_r;
            end
        end else if (ras_pop_s) begin
            ras_ptr_r   <= ras_prev_s;
            ras_count_r <= ras_count_r - 1'b1;
        end else begin
            ras_ptr_r   <= ras_ptr_r;
            ras_count_r <= ras_count_r;
        end
    end
`endif

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign halted      = halted_r;

endmodule
